imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, registered immediate-extension stage for the SimpleCPU decode->execute path.
//  Extends an IMM_W-bit immediate to DATA_W bits in one of four modes:
//    - zero extension
//    - sign extension
//    - upper placement (LUI)
//    - sign-extend-and-shift (branch offset)
//  A valid/ready handshake with a 2-entry skid buffer gives full throughput, and a sideband tag
//  travels with each result.
// PARAMETERS
//  IMM_W     16  immediate input width
//  DATA_W    32  result width; must be >= IMM_W + BR_SHIFT
//  BR_SHIFT  2   left shift applied in branch mode
//  TAG_W     5   sideband tag width (e.g. destination register index)
// PORTS
//  CLK        in   1       rising-edge clock
//  Reset      in   1       synchronous reset, active-low (0 = reset)
//  Flush      in   1       synchronous pipeline flush, active-high
//  ExtMode    in   2       00 zero, 01 sign, 10 upper, 11 branch
//  immediate  in   IMM_W   immediate field
//  tag_in     in   TAG_W   sideband, carried unmodified
//  in_valid   in   1       input beat valid
//  in_ready   out  1       stage can accept a beat this cycle
//  Extendout  out  DATA_W  extended result
//  tag_out    out  TAG_W   tag belonging to Extendout
//  out_valid  out  1       Extendout/tag_out valid
//  out_ready  in   1       consumer accepts the beat this cycle
// BEHAVIOUR
//  Arithmetic (s = immediate[IMM_W-1] for modes 01 and 11):
//   - 00: {(DATA_W-IMM_W){0}, immediate}
//   - 01: {(DATA_W-IMM_W){s}, immediate}
//   - 10: immediate << (DATA_W-IMM_W); low bits are 0
//   - 11: sign-extended value << BR_SHIFT; low BR_SHIFT bits are 0
//   - No bits are lost: the parameter rule guarantees this.
//   - The mode is sampled with its beat; changing ExtMode later never alters a stored result.
//  Handshake:
//   - in_fire  = in_valid & in_ready
//   - out_fire = out_valid & out_ready
//   - in_ready = Reset & ~Flush & ~skid_valid
//   - in_ready is not combinationally dependent on out_ready.
//   - While out_valid=1 and out_ready=0, Extendout and tag_out hold stable.
//   - Beats leave in acceptance order.
//  Latency:
//   - Accepted at edge N, the result is visible on Extendout after edge N (out_valid=1 in cycle N+1)
//     when the stage was empty, or when it held one beat that out_fire consumed at edge N.
//  States (out_valid, skid_valid):
//   - EMPTY (0,0)
//       in_fire        -> ONE; result loads into the output register
//   - ONE (1,0)
//       out_fire&in_fire   -> ONE; new result loads into the output register
//       out_fire&~in_fire  -> EMPTY
//       ~out_fire&in_fire  -> FULL; new result loads into the skid register
//       neither            -> ONE, hold
//   - FULL (1,1); in_ready=0
//       out_fire   -> ONE; skid contents move to the output register
//       ~out_fire  -> FULL, hold
//  Flush:
//   - Next state is EMPTY, dropping both entries.
//   - Overrides every simultaneous event. No accept can occur: in_ready=0 during Flush.
//   - Data registers are don't-care once flushed; out_valid is the only qualifier.
//  Reset:
//   - While Reset=0: in_ready=0.
//   - After the edge with Reset=0: out_valid=0, skid_valid=0, Extendout=0, tag_out=0.
//   - Reset mid-transfer discards buffered beats exactly as Flush does.
//   - in_ready=1 in the first cycle after Reset returns to 1.
// TESTING
//  1. Reset low 2 cycles, then high -> out_valid=0, Extendout=0, in_ready=1 in the first cycle after release.
//  2. Mode 01, imm 16'h8001, tag 3, out_ready=1 -> next cycle Extendout=32'hFFFF8001, tag_out=3.
//     Mode 00, same imm -> 32'h00008001.
//  3. Mode 10, imm 16'h1234 -> 32'h12340000. Mode 11, imm 16'hFFFE -> 32'hFFFFFFF8.
//     Mode 11, imm 16'h7FFF -> 32'h0001FFFC.
//  4. out_ready=0, send beats A=16'h0001 and B=16'h0002 (mode 00) back-to-back -> after B, in_ready=0
//     and Extendout=1 holds. Raise out_ready -> outputs 1 then 2 on consecutive cycles; in_ready returns to 1.
//  5. FULL state, assert Flush 1 cycle with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle,
//     and the beat offered during Flush is not accepted.
//  6. Back-to-back stream of 8 beats, out_ready=1 throughout -> one result per cycle, no bubbles,
//     tags preserved in order.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: valid/ready bus carrying an immediate beat in and its extended result out
interface imm_extend_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic [1:0]        ExtMode;
  logic [IMM_W-1:0]  immediate;
  logic [TAG_W-1:0]  tag_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Extendout;
  logic [TAG_W-1:0]  tag_out;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output ExtMode, immediate, tag_in, in_valid, out_ready,
    input  in_ready, Extendout, tag_out, out_valid
  );
  modport slave (
    input  ExtMode, immediate, tag_in, in_valid, out_ready,
    output in_ready, Extendout, tag_out, out_valid
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extension (zero/sign/upper/branch) behind a 2-entry skid buffer
module imm_extend_pipe #(
  parameter int IMM_W    = 16,
  parameter int DATA_W   = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Flush,
  imm_extend_pipe_if.slave io
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic [DATA_W-1:0] zx, sx, ext;
  logic              in_ready, out_valid, in_fire, out_fire;
  always_comb begin
    zx  = DATA_W'(io.immediate);
    sx  = DATA_W'($signed(io.immediate));
    ext = io.ExtMode == 2'b00 ? zx :
          io.ExtMode == 2'b01 ? sx :
          io.ExtMode == 2'b10 ? zx << (DATA_W - IMM_W) : sx << BR_SHIFT;
  end
  // in_ready looks only at local state so it never depends on out_ready
  assign in_ready  = Reset & ~Flush & (state_q != FULL);
  assign out_valid = state_q != EMPTY;
  assign in_fire   = io.in_valid & in_ready;
  assign out_fire  = out_valid & io.out_ready;
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d    = ONE;
        out_data_d = ext;
        out_tag_d  = io.tag_in;
      end
      ONE: if (in_fire && out_fire) begin
        out_data_d = ext;
        out_tag_d  = io.tag_in;
      end else if (out_fire) begin
        state_d = EMPTY;
      end else if (in_fire) begin
        state_d     = FULL;
        skid_data_d = ext;
        skid_tag_d  = io.tag_in;
      end
      FULL: if (out_fire) begin
        state_d    = ONE;
        out_data_d = skid_data_q;
        out_tag_d  = skid_tag_q;
      end
      default: state_d = EMPTY;
    endcase
    if (Flush) state_d = EMPTY;
  end
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end
  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.Extendout = out_data_q;
  assign io.tag_out   = out_tag_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed vectors with a scoreboard queue checked by a separate output monitor
module tb_imm_extend_pipe;
  logic CLK = 0, Reset = 0, Flush = 0;
  int total = 0, bad = 0, cyc = 0;
  logic [36:0] q[$];
  int pops[$];
  logic [36:0] e;
  imm_extend_pipe_if #(.IMM_W(16), .DATA_W(32), .TAG_W(5)) io ();
  imm_extend_pipe #(.IMM_W(16), .DATA_W(32), .BR_SHIFT(2), .TAG_W(5)) dut (
    .CLK(CLK), .Reset(Reset), .Flush(Flush), .io(io)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, x);
    end
  endtask
  always @(negedge CLK) begin
    if (Reset && !Flush && io.out_valid && io.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat got=%0h want=none", io.Extendout);
      end else begin
        e = q.pop_front();
        chk("out_data", io.Extendout, e[31:0]);
        chk("out_tag", io.tag_out, e[36:32]);
        pops.push_back(cyc);
      end
    end
  end
  task automatic send(input logic [1:0] m, input logic [15:0] imm, input logic [4:0] t, input logic [31:0] x);
    int n = 0;
    @(negedge CLK);
    io.ExtMode = m; io.immediate = imm; io.tag_in = t; io.in_valid = 1;
    while (!io.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!io.in_ready) chk("send_timeout", 0, 1);
    else q.push_back({t, x});
    @(posedge CLK);
  endtask
  task automatic idle();
    @(negedge CLK);
    io.in_valid = 0;
  endtask
  logic [1:0]  vm [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [15:0] vi [8] = '{16'h00FF, 16'hFF00, 16'hABCD, 16'h0001, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
  logic [31:0] vx [8] = '{32'h000000FF, 32'hFFFFFF00, 32'hABCD0000, 32'h00000004,
                          32'h00007FFF, 32'hFFFE0000, 32'h00010000, 32'h0000FFFF};
  initial begin
    int n;
    io.ExtMode = 0; io.immediate = 0; io.tag_in = 0; io.in_valid = 0; io.out_ready = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready_low", io.in_ready, 0);
    Reset = 1;
    @(negedge CLK);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_extendout", io.Extendout, 0);
    chk("rst_tag_out", io.tag_out, 0);
    chk("rst_in_ready", io.in_ready, 1);
    send(2'b01, 16'h8001, 5'd3, 32'hFFFF8001);
    send(2'b00, 16'h8001, 5'd4, 32'h00008001);
    send(2'b10, 16'h1234, 5'd5, 32'h12340000);
    send(2'b11, 16'hFFFE, 5'd6, 32'hFFFFFFF8);
    send(2'b11, 16'h7FFF, 5'd7, 32'h0001FFFC);
    idle();
    repeat (3) @(negedge CLK);
    io.out_ready = 0;
    send(2'b00, 16'h0001, 5'd8, 32'h1);
    send(2'b00, 16'h0002, 5'd9, 32'h2);
    io.ExtMode = 2'b01;
    idle();
    chk("full_in_ready", io.in_ready, 0);
    chk("full_out_valid", io.out_valid, 1);
    chk("full_hold_a", io.Extendout, 1);
    repeat (2) @(negedge CLK);
    chk("hold_a_later", io.Extendout, 1);
    chk("hold_tag_later", io.tag_out, 8);
    pops.delete();
    io.out_ready = 1;
    repeat (3) @(negedge CLK);
    chk("drain_pops", pops.size(), 2);
    if (pops.size() == 2) chk("drain_consecutive", pops[1] - pops[0], 1);
    chk("drain_in_ready", io.in_ready, 1);
    io.out_ready = 0;
    send(2'b00, 16'h0003, 5'd10, 32'h3);
    send(2'b00, 16'h0004, 5'd11, 32'h4);
    @(negedge CLK);
    Flush = 1; io.in_valid = 1; io.immediate = 16'h0055; io.tag_in = 5'd12;
    chk("flush_in_ready", io.in_ready, 0);
    q.delete();
    @(negedge CLK);
    Flush = 0; io.in_valid = 0;
    chk("flush_out_valid", io.out_valid, 0);
    io.out_ready = 1;
    repeat (2) @(negedge CLK);
    chk("flush_no_accept", io.out_valid, 0);
    pops.delete();
    for (int i = 0; i < 8; i++) send(vm[i], vi[i], 5'(16 + i), vx[i]);
    idle();
    repeat (3) @(negedge CLK);
    chk("stream_pops", pops.size(), 8);
    if (pops.size() == 8)
      for (int i = 0; i < 7; i++) chk("stream_no_bubble", pops[i+1] - pops[i], 1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
